// File: rtl/bullet_controller_if.sv
// Control handshake between the game logic and one bullet controller: fire request/ack,
// frame tick, hit pulse, and the bullet's live position/state.
interface bullet_controller_if;
  logic       Frame_Tick_In;
  logic       Fire_In;
  logic [9:0] Fire_X_In;
  logic [9:0] Fire_Y_In;
  logic [1:0] Direction_In;
  logic       Hit_In;
  logic       Fire_Ack_Out;
  logic       Active_Out;
  logic [9:0] Bullet_X_Out;
  logic [9:0] Bullet_Y_Out;

  modport master (
    output Frame_Tick_In, Fire_In, Fire_X_In, Fire_Y_In, Direction_In, Hit_In,
    input  Fire_Ack_Out, Active_Out, Bullet_X_Out, Bullet_Y_Out
  );

  modport slave (
    input  Frame_Tick_In, Fire_In, Fire_X_In, Fire_Y_In, Direction_In, Hit_In,
    output Fire_Ack_Out, Active_Out, Bullet_X_Out, Bullet_Y_Out
  );
endinterface

// File: rtl/bullet_controller.sv
// Single-bullet controller: fire/fly/kill FSM stepping once per frame, plus a 3-stage
// render pipeline that addresses the sprite ROM and composites over the background.
module bullet_controller #(
  parameter int unsigned SPRITE_SIZE = 10,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned SPEED       = 4,
  parameter logic [11:0] KEY_COLOUR  = 12'hFFF
) (
  input  logic                        Master_Clock_In,
  input  logic                        Reset_In,
  bullet_controller_if.slave          ctrl,
  input  logic [9:0]                  xInput,
  input  logic [9:0]                  yInput,
  input  logic [11:0]                 Background_In,
  output logic [9:0]                  Sprite_X_Out,
  output logic [9:0]                  Sprite_Y_Out,
  input  logic [11:0]                 Sprite_Colour_In,
  output logic [11:0]                 ColourData
);

  localparam logic [11:0] LIM_X = 12'(SCREEN_W - SPRITE_SIZE);
  localparam logic [11:0] LIM_Y = 12'(SCREEN_H - SPRITE_SIZE);
  localparam logic [11:0] STEP  = 12'(SPEED);
  localparam logic [10:0] SIZE  = 11'(SPRITE_SIZE);

  typedef enum logic {StIdle, StFlying} state_e;

  state_e      r_state, w_state_next;
  logic [9:0]  r_bx, r_by, w_bx_next, w_by_next;
  logic [1:0]  r_dir, w_dir_next;
  logic        r_ack, w_ack_next;
  logic [11:0] w_step_x, w_step_y;

  // 12-bit step: an underflow wraps to a huge value, so one upper-bound test covers both edges.
  always_comb begin
    w_step_x = {2'b00, r_bx};
    w_step_y = {2'b00, r_by};
    unique case (r_dir)
      2'b00: w_step_y = {2'b00, r_by} - STEP;
      2'b01: w_step_y = {2'b00, r_by} + STEP;
      2'b10: w_step_x = {2'b00, r_bx} - STEP;
      2'b11: w_step_x = {2'b00, r_bx} + STEP;
      default: ;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_bx_next    = r_bx;
    w_by_next    = r_by;
    w_dir_next   = r_dir;
    w_ack_next   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (ctrl.Fire_In) begin
          w_bx_next    = ({2'b00, ctrl.Fire_X_In} > LIM_X) ? LIM_X[9:0] : ctrl.Fire_X_In;
          w_by_next    = ({2'b00, ctrl.Fire_Y_In} > LIM_Y) ? LIM_Y[9:0] : ctrl.Fire_Y_In;
          w_dir_next   = ctrl.Direction_In;
          w_ack_next   = 1'b1;
          w_state_next = StFlying;
        end
      end
      StFlying: begin
        if (ctrl.Hit_In) begin
          w_state_next = StIdle;
        end else if (ctrl.Frame_Tick_In) begin
          if (w_step_x > LIM_X || w_step_y > LIM_Y) begin
            w_state_next = StIdle;
          end else begin
            w_bx_next = w_step_x[9:0];
            w_by_next = w_step_y[9:0];
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge Master_Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_state <= StIdle;
      r_bx    <= '0;
      r_by    <= '0;
      r_dir   <= 2'b00;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_bx    <= w_bx_next;
      r_by    <= w_by_next;
      r_dir   <= w_dir_next;
      r_ack   <= w_ack_next;
    end
  end

  assign ctrl.Fire_Ack_Out = r_ack;
  assign ctrl.Active_Out   = (r_state == StFlying);
  assign ctrl.Bullet_X_Out = r_bx;
  assign ctrl.Bullet_Y_Out = r_by;

  // Render pipeline: S1 hit-test and ROM address, S2 waits on ROM, S3 composite.
  logic [10:0] w_x11, w_y11, w_bx11, w_by11;
  logic        w_inside;
  logic        r_in1, r_in2;
  logic [11:0] r_bg1, r_bg2, r_colour;
  logic [9:0]  r_sx, r_sy;

  assign w_x11  = {1'b0, xInput};
  assign w_y11  = {1'b0, yInput};
  assign w_bx11 = {1'b0, r_bx};
  assign w_by11 = {1'b0, r_by};
  assign w_inside = ctrl.Active_Out
                  && (w_x11 >= w_bx11) && (w_x11 < w_bx11 + SIZE)
                  && (w_y11 >= w_by11) && (w_y11 < w_by11 + SIZE);

  always_ff @(posedge Master_Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_in1    <= 1'b0;
      r_in2    <= 1'b0;
      r_sx     <= '0;
      r_sy     <= '0;
      r_bg1    <= '0;
      r_bg2    <= '0;
      r_colour <= '0;
    end else begin
      r_in1    <= w_inside;
      r_sx     <= w_inside ? (xInput - r_bx) : 10'd0;
      r_sy     <= w_inside ? (yInput - r_by) : 10'd0;
      r_bg1    <= Background_In;
      r_in2    <= r_in1;
      r_bg2    <= r_bg1;
      r_colour <= (r_in2 && (Sprite_Colour_In != KEY_COLOUR)) ? Sprite_Colour_In : r_bg2;
    end
  end

  assign Sprite_X_Out = r_sx;
  assign Sprite_Y_Out = r_sy;
  assign ColourData   = r_colour;

endmodule

// File: tb/tb_bullet_controller.sv
// Directed bench for bullet_controller: expected acks and render results are queued at
// stimulus time and popped by a negedge monitor when the DUT presents them.
module tb_bullet_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bullet_controller_if ctrl();
  logic [9:0]  x_in = '0, y_in = '0, sx, sy;
  logic [11:0] bg_in = '0, rom_col = '0, colour;

  bullet_controller dut (
    .Master_Clock_In (clk),
    .Reset_In        (rst),
    .ctrl            (ctrl),
    .xInput          (x_in),
    .yInput          (y_in),
    .Background_In   (bg_in),
    .Sprite_X_Out    (sx),
    .Sprite_Y_Out    (sy),
    .Sprite_Colour_In(rom_col),
    .ColourData      (colour)
  );

  typedef struct {logic [9:0] a; logic [9:0] b;} pair_t;
  pair_t       ack_q[$], spr_q[$];
  logic [11:0] col_q[$];
  pair_t       mon_e;
  logic [11:0] mon_c;
  int n_vec = 0;
  int n_err = 0;

  // ROM stand-in: returns the colour chosen for a vector two cycles after it was driven.
  logic        drv_vld = 1'b0, p1 = 1'b0, p2 = 1'b0, p3 = 1'b0;
  logic [11:0] drv_rom = '0, rc1 = '0;
  always @(posedge clk) begin
    p1 <= drv_vld;
    p2 <= p1;
    p3 <= p2;
    rc1 <= drv_rom;
    rom_col <= rc1;
  end

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (ctrl.Fire_Ack_Out === 1'b1) begin
      if (ack_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ack: got ack at %0t, expected none", $time);
      end else begin
        mon_e = ack_q.pop_front();
        chk("ack_x", {2'b00, ctrl.Bullet_X_Out}, {2'b00, mon_e.a});
        chk("ack_y", {2'b00, ctrl.Bullet_Y_Out}, {2'b00, mon_e.b});
        chk("ack_active", {11'd0, ctrl.Active_Out}, 12'd1);
      end
    end
    if (p1) begin
      if (spr_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sprite_q_empty: got output, expected none");
      end else begin
        mon_e = spr_q.pop_front();
        chk("sprite_x", {2'b00, sx}, {2'b00, mon_e.a});
        chk("sprite_y", {2'b00, sy}, {2'b00, mon_e.b});
      end
    end
    if (p3) begin
      if (col_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL colour_q_empty: got output, expected none");
      end else begin
        mon_c = col_q.pop_front();
        chk("colour", colour, mon_c);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    ctrl.Frame_Tick_In = 1'b1;
    step();
    ctrl.Frame_Tick_In = 1'b0;
  endtask

  task automatic fire(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d,
                      input logic [9:0] ex, input logic [9:0] ey);
    ctrl.Fire_In = 1'b1;
    ctrl.Fire_X_In = x;
    ctrl.Fire_Y_In = y;
    ctrl.Direction_In = d;
    ack_q.push_back('{ex, ey});
    step();
    ctrl.Fire_In = 1'b0;
    step();
  endtask

  task automatic rv(input logic [9:0] x, input logic [9:0] y, input logic [11:0] bg,
                    input logic [11:0] rom, input logic [9:0] esx, input logic [9:0] esy,
                    input logic [11:0] ecol);
    x_in = x;
    y_in = y;
    bg_in = bg;
    drv_rom = rom;
    drv_vld = 1'b1;
    spr_q.push_back('{esx, esy});
    col_q.push_back(ecol);
    step();
  endtask

  task automatic chk_at_negedge(input string name, input logic [11:0] act_sel,
                                input logic [11:0] exp);
    chk(name, act_sel, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ctrl.Frame_Tick_In = 1'b0;
    ctrl.Fire_In = 1'b0;
    ctrl.Fire_X_In = '0;
    ctrl.Fire_Y_In = '0;
    ctrl.Direction_In = 2'b00;
    ctrl.Hit_In = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("rst_active", {11'd0, ctrl.Active_Out}, 12'd0);
    chk("rst_ack", {11'd0, ctrl.Fire_Ack_Out}, 12'd0);
    chk("rst_bx", {2'b00, ctrl.Bullet_X_Out}, 12'd0);
    chk("rst_sx", {2'b00, sx}, 12'd0);
    chk("rst_colour", colour, 12'h000);
    rst = 1'b0;
    step();

    // Fire right from (100,200), then render against the tile.
    fire(10'd100, 10'd200, 2'b11, 10'd100, 10'd200);
    chk("fly_active", {11'd0, ctrl.Active_Out}, 12'd1);
    rv(10'd104, 10'd204, 12'h0A0, 12'hFFF, 10'd4, 10'd4, 12'h0A0);
    rv(10'd104, 10'd204, 12'h0A0, 12'h000, 10'd4, 10'd4, 12'h000);
    rv(10'd110, 10'd204, 12'h0A0, 12'h000, 10'd0, 10'd0, 12'h0A0);
    rv(10'd100, 10'd200, 12'h555, 12'hF00, 10'd0, 10'd0, 12'hF00);
    rv(10'd109, 10'd209, 12'h555, 12'h00F, 10'd9, 10'd9, 12'h00F);
    rv(10'd99,  10'd205, 12'h555, 12'h0F0, 10'd0, 10'd0, 12'h555);
    rv(10'd105, 10'd210, 12'h321, 12'h0F0, 10'd0, 10'd0, 12'h321);
    drv_vld = 1'b0;
    for (int i = 0; i < 10 && (spr_q.size() != 0 || col_q.size() != 0); i++) step();
    chk("render_drained", 12'(spr_q.size() + col_q.size()), 12'd0);

    tick(); tick(); tick();
    chk("move_x", {2'b00, ctrl.Bullet_X_Out}, 12'd112);
    chk("move_y", {2'b00, ctrl.Bullet_Y_Out}, 12'd200);
    ctrl.Hit_In = 1'b1;
    step();
    ctrl.Hit_In = 1'b0;
    chk("hit_kill", {11'd0, ctrl.Active_Out}, 12'd0);

    // Leftward exit at the screen edge.
    fire(10'd6, 10'd100, 2'b10, 10'd6, 10'd100);
    tick();
    chk("left_x1", {2'b00, ctrl.Bullet_X_Out}, 12'd2);
    chk("left_act1", {11'd0, ctrl.Active_Out}, 12'd1);
    tick();
    chk("left_x2", {2'b00, ctrl.Bullet_X_Out}, 12'd2);
    chk("left_act2", {11'd0, ctrl.Active_Out}, 12'd0);

    // Hit wins over a simultaneous tick.
    fire(10'd300, 10'd50, 2'b00, 10'd300, 10'd50);
    ctrl.Hit_In = 1'b1;
    ctrl.Frame_Tick_In = 1'b1;
    step();
    ctrl.Hit_In = 1'b0;
    ctrl.Frame_Tick_In = 1'b0;
    chk("hit_tick_act", {11'd0, ctrl.Active_Out}, 12'd0);
    chk("hit_tick_y", {2'b00, ctrl.Bullet_Y_Out}, 12'd50);

    // Fire held while flying is left pending, then accepted with clamped coordinates.
    fire(10'd200, 10'd100, 2'b01, 10'd200, 10'd100);
    ctrl.Fire_In = 1'b1;
    ctrl.Fire_X_In = 10'd1000;
    ctrl.Fire_Y_In = 10'd1000;
    ctrl.Direction_In = 2'b01;
    step(); step(); step();
    chk("pend_active", {11'd0, ctrl.Active_Out}, 12'd1);
    chk("pend_bx", {2'b00, ctrl.Bullet_X_Out}, 12'd200);
    ack_q.push_back('{10'd630, 10'd470});
    ctrl.Hit_In = 1'b1;
    step();
    ctrl.Hit_In = 1'b0;
    step();
    ctrl.Fire_In = 1'b0;
    step();
    chk("acks_drained", 12'(ack_q.size()), 12'd0);

    // Render the clamped tile, then reset between clock edges.
    x_in = 10'd632;
    y_in = 10'd475;
    bg_in = 12'h0A0;
    drv_rom = 12'h00F;
    step(); step(); step(); step();
    @(negedge clk);
    chk("pre_rst_colour", colour, 12'h00F);
    chk("pre_rst_sx", {2'b00, sx}, 12'd2);
    chk("pre_rst_sy", {2'b00, sy}, 12'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("async_active", {11'd0, ctrl.Active_Out}, 12'd0);
    chk("async_colour", colour, 12'h000);
    chk("async_bx", {2'b00, ctrl.Bullet_X_Out}, 12'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_colour", colour, (i < 2) ? 12'h000 : 12'h0A0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
